sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sound-effect scheduler that shares the single sine-tone generator (32-entry tone ROM driving `tono`) among game events. It latches one-cycle event requests (paddle hit, wall bounce, brick erase, game over) and arbitrates them by fixed priority. It then plays each event as a short note sequence and produces the ROM address stream entirely in the `clk50mhz` domain, with no gated or muxed clocks. It sits between the paddle/ball logic and the tone ROM in `Main`.

## Interface
- `TICK_DIV`, 500000, `clk50mhz` cycles per duration tick (10 ms); range 1..2^20-1.
- `clk50mhz`  in  1  system clock, 50 MHz.
- `reset_button`  in  1  asynchronous, active-high reset.
- `sfx_req`  in  4  one-cycle request pulses: [0] paddle hit, [1] wall bounce, [2] brick erase, [3] game over. Higher index means higher priority.
- `audio_addr`  out  5  tone ROM address.
- `tone_en`  out  1  a note is sounding; the downstream gate forces `tono`=0 when low.
- `busy`  out  1  a sound is active (equals `tone_en`).
- `active_id`  out  2  index of the sound currently playing.
- `pending`  out  4  latched, not-yet-started requests.

## Operation
- Note half-periods (HP, in cycles) are fixed constants: C=0xBAA, D=0xA64, E=0x941, G=0x7C9.
- Sound tables, as (note, ticks):
  - id0: G5.
  - id1: C3.
  - id2: E4, G4.
  - id3: G20, E20, D20, C40.
- Pending latch:
  - Bit `i` is set on any cycle where `sfx_req[i]`=1.
  - The bit clears when sound `i` starts.
  - If set and clear coincide, set wins and the request stays pending.
  - Re-requesting the playing id latches a replay that runs after the current sound.
- FSM states: IDLE and PLAY.
  - IDLE, `pending`≠0: start the highest pending id, go to PLAY.
  - PLAY, note ends and notes remain: load the next note, stay in PLAY.
  - PLAY, last note ends: go to IDLE. This gives exactly one IDLE cycle before any further pending sound starts.
  - PLAY, a pending bit with index > `active_id` is set: preempt by starting that id next cycle. The preempted sound is discarded and never resumed.
  - Pending bits with index ≤ `active_id` wait.
- Sound start:
  - `active_id` := id.
  - Note index := 0.
  - `tick_cnt`, `dur_cnt` and `phase_cnt` := 0.
  - `audio_addr` := 0.
- Duration counters:
  - `tick_cnt` counts 0..TICK_DIV-1.
  - `dur_cnt` increments when `tick_cnt` wraps.
  - The note ends on the cycle where `tick_cnt`=TICK_DIV-1 and `dur_cnt`=DUR-1, so a note lasts exactly DUR×TICK_DIV cycles.
  - On a note change, `tick_cnt`, `dur_cnt` and `phase_cnt` reset to 0.
  - `audio_addr` is not reset on a note change; phase stays continuous across notes.
- Phase counter:
  - `phase_cnt` counts 0..2·HP-1 (13 bits).
  - On wrap, `audio_addr` increments modulo 32 (31→0).
  - One ROM cycle is 64·HP clocks, so C plays at 261.6 Hz.
- In IDLE: `audio_addr`=0, `tone_en`=0, and all counters are held at 0.

## Timing
- Reset (asynchronous, immediate):
  - `audio_addr`=0, `tone_en`=0, `busy`=0, `active_id`=0, `pending`=0, state IDLE.
  - Reset mid-sound aborts the sound and drops all pending requests.
- Latency:
  - A request sampled at edge N sets `pending` after edge N.
  - When idle, `tone_en`=1, `busy`=1 and `active_id` are valid after edge N+1, and the pending bit is 0 at the same point.
  - Preemption follows the same timing: the new `active_id` is visible after edge N+1.
- End of sound: `tone_en` falls after the edge completing the last note's DUR×TICK_DIV cycles.
- Simultaneous requests are resolved by priority in the same IDLE cycle. The loser stays pending.
- All outputs are registered.

## Test plan
- **Reset:** assert `reset_button` mid-id3 playback → all outputs 0 in the same cycle, asynchronously. After release, with no requests, `busy` stays 0.
- **Single request** (TICK_DIV=4): pulse `sfx_req`=4'b0001 at edge 0 → `pending`=0001 after edge 0; after edge 1, `tone_en`=1, `active_id`=0 and `pending`=0; `tone_en` stays high exactly 20 cycles; `audio_addr` stays 0.
- **Simultaneous requests** (TICK_DIV=4): `sfx_req`=4'b0110 at one edge → id2 plays 32 cycles while `pending`=0010, then exactly one cycle with `tone_en`=0, then id1 plays 12 cycles, then idle.
- **Preemption** (TICK_DIV=4): id0 playing, pulse `sfx_req[3]` 10 cycles in → `active_id`=3 and `audio_addr`=0 two edges later; busy for 400 cycles; id0 never resumes; final `pending`=0.
- **Lower-priority wait** (TICK_DIV=4): pulse `sfx_req[1]` during id3 → `pending`=0010 held; id1 starts one idle cycle after id3 ends.
- **Address stepping** (TICK_DIV=1000, id3):
  - `audio_addr` increments every 3986 cycles during the first note (G); `audio_addr`=5 at its end (20000 cycles).
  - During note E it increments every 4738 cycles, starting from 5.
  - 31 wraps to 0 when exercised with a long run.

Source files
------------

// File: rtl/sfx_scheduler_if.sv
// sfx_scheduler_if: request pulses in, tone ROM address and status out
interface sfx_scheduler_if;
  logic [3:0] sfx_req;
  logic [4:0] audio_addr;
  logic       tone_en;
  logic       busy;
  logic [1:0] active_id;
  logic [3:0] pending;
  modport master (output sfx_req, input audio_addr, tone_en, busy, active_id, pending);
  modport slave  (input sfx_req, output audio_addr, tone_en, busy, active_id, pending);
endinterface

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect sequencer producing the tone ROM address stream
module sfx_scheduler #(
  parameter int unsigned TICK_DIV = 500000
) (
  input logic            clk50mhz,
  input logic            reset_button,
  sfx_scheduler_if.slave bus
);
  localparam logic [11:0] HP_C = 12'hBAA, HP_D = 12'hA64, HP_E = 12'h941, HP_G = 12'h7C9;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t      state;
  logic [3:0]  pending;
  logic [1:0]  active_id, note_idx, last_idx, top_id;
  logic [19:0] tick_cnt;
  logic [5:0]  dur_cnt, dur;
  logic [12:0] phase_cnt;
  logic [4:0]  audio_addr;
  logic        tone_en, start, phase_wrap, tick_wrap, note_end;
  logic [11:0] hp;
  always_comb begin
    {hp, dur} = {HP_G, 6'd5};
    case ({active_id, note_idx})
      4'b01_00: {hp, dur} = {HP_C, 6'd3};
      4'b10_00: {hp, dur} = {HP_E, 6'd4};
      4'b10_01: {hp, dur} = {HP_G, 6'd4};
      4'b11_00: {hp, dur} = {HP_G, 6'd20};
      4'b11_01: {hp, dur} = {HP_E, 6'd20};
      4'b11_10: {hp, dur} = {HP_D, 6'd20};
      4'b11_11: {hp, dur} = {HP_C, 6'd40};
      default:  {hp, dur} = {HP_G, 6'd5};
    endcase
  end
  assign last_idx   = active_id == 2'd3 ? 2'd3 : active_id == 2'd2 ? 2'd1 : 2'd0;
  assign top_id     = pending[3] ? 2'd3 : pending[2] ? 2'd2 : pending[1] ? 2'd1 : 2'd0;
  // in PLAY only a strictly higher id may cut in; equal or lower ids wait
  assign start      = state == IDLE ? |pending : top_id > active_id;
  assign phase_wrap = phase_cnt == {hp, 1'b0} - 13'd1;
  assign tick_wrap  = tick_cnt == 20'(TICK_DIV - 1);
  assign note_end   = tick_wrap && dur_cnt == dur - 6'd1;
  always_ff @(posedge clk50mhz or posedge reset_button) begin
    if (reset_button) begin
      state      <= IDLE;
      pending    <= '0;
      active_id  <= '0;
      note_idx   <= '0;
      tick_cnt   <= '0;
      dur_cnt    <= '0;
      phase_cnt  <= '0;
      audio_addr <= '0;
      tone_en    <= 1'b0;
    end else begin
      pending <= (pending & ~(start ? 4'b1 << top_id : 4'b0)) | bus.sfx_req;
      if (start) begin
        state      <= PLAY;
        active_id  <= top_id;
        note_idx   <= '0;
        tick_cnt   <= '0;
        dur_cnt    <= '0;
        phase_cnt  <= '0;
        audio_addr <= '0;
        tone_en    <= 1'b1;
      end else if (state == PLAY) begin
        phase_cnt  <= phase_wrap ? 13'd0 : phase_cnt + 13'd1;
        audio_addr <= audio_addr + 5'(phase_wrap);
        tick_cnt   <= tick_wrap ? 20'd0 : tick_cnt + 20'd1;
        dur_cnt    <= dur_cnt + 6'(tick_wrap);
        // address keeps running across notes so the waveform stays phase-continuous
        if (note_end) begin
          tick_cnt  <= '0;
          dur_cnt   <= '0;
          phase_cnt <= '0;
          if (note_idx == last_idx) begin
            state      <= IDLE;
            tone_en    <= 1'b0;
            audio_addr <= '0;
          end else begin
            note_idx <= note_idx + 2'd1;
          end
        end
      end
    end
  end
  assign bus.audio_addr = audio_addr;
  assign bus.tone_en    = tone_en;
  assign bus.busy       = tone_en;
  assign bus.active_id  = active_id;
  assign bus.pending    = pending;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: two scheduler instances (short and long tick) checked against a note-level model
module tb_sfx_scheduler;
  logic clk50mhz = 1'b0;
  logic reset_button = 1'b0;
  int errors = 0;
  int checks = 0;
  always #10 clk50mhz = ~clk50mhz;
  sfx_scheduler_if ia ();
  sfx_scheduler_if ib ();
  sfx_scheduler #(.TICK_DIV(4))    dut_a (.clk50mhz(clk50mhz), .reset_button(reset_button), .bus(ia.slave));
  sfx_scheduler #(.TICK_DIV(1000)) dut_b (.clk50mhz(clk50mhz), .reset_button(reset_button), .bus(ib.slave));
  int         td [2] = '{4, 1000};
  bit         play [2];
  int         id [2], note [2], el [2], base [2];
  logic [3:0] pend [2];
  function automatic int hp_of(int i, int n);
    if (i == 0) return 'h7C9;
    if (i == 1) return 'hBAA;
    if (i == 2) return n == 0 ? 'h941 : 'h7C9;
    return n == 0 ? 'h7C9 : n == 1 ? 'h941 : n == 2 ? 'hA64 : 'hBAA;
  endfunction
  function automatic int dur_of(int i, int n);
    if (i == 0) return 5;
    if (i == 1) return 3;
    if (i == 2) return 4;
    return n == 3 ? 40 : 20;
  endfunction
  function automatic int notes_of(int i);
    return i == 3 ? 4 : i == 2 ? 2 : 1;
  endfunction
  function automatic int highest(logic [3:0] p);
    for (int b = 3; b >= 0; b--) if (p[b]) return b;
    return -1;
  endfunction
  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      play[k] = 0; id[k] = 0; note[k] = 0; el[k] = 0; base[k] = 0; pend[k] = '0;
    end
  endtask
  task automatic step(int k, logic [3:0] r);
    int h, hp, d;
    h = highest(pend[k]);
    if (h >= 0 && (!play[k] || h > id[k])) begin
      play[k] = 1; id[k] = h; note[k] = 0; el[k] = 0; base[k] = 0;
      pend[k][h] = 1'b0;
    end else if (play[k]) begin
      hp = hp_of(id[k], note[k]);
      d  = dur_of(id[k], note[k]);
      el[k]++;
      if (el[k] == d * td[k]) begin
        base[k] = (base[k] + el[k] / (2 * hp)) % 32;
        el[k] = 0;
        if (note[k] == notes_of(id[k]) - 1) play[k] = 0;
        else note[k]++;
      end
    end
    pend[k] = pend[k] | r;
  endtask
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_all(int k);
    logic [4:0] ad;
    logic       en, bz;
    logic [1:0] aid;
    logic [3:0] pd;
    int         ea;
    if (k == 0) {ad, en, bz, aid, pd} = {ia.audio_addr, ia.tone_en, ia.busy, ia.active_id, ia.pending};
    else        {ad, en, bz, aid, pd} = {ib.audio_addr, ib.tone_en, ib.busy, ib.active_id, ib.pending};
    ea = play[k] ? (base[k] + el[k] / (2 * hp_of(id[k], note[k]))) % 32 : 0;
    chk($sformatf("tone_en[%0d]", k), int'(en), int'(play[k]));
    chk($sformatf("busy[%0d]", k), int'(bz), int'(play[k]));
    chk($sformatf("audio_addr[%0d]", k), int'(ad), ea);
    chk($sformatf("pending[%0d]", k), int'(pd), int'(pend[k]));
    if (play[k]) chk($sformatf("active_id[%0d]", k), int'(aid), id[k]);
  endtask
  task automatic cyc(logic [3:0] ra, logic [3:0] rb);
    ia.sfx_req = ra;
    ib.sfx_req = rb;
    @(posedge clk50mhz);
    step(0, ra);
    step(1, rb);
    #1;
    check_all(0);
    check_all(1);
  endtask
  task automatic rst_pulse();
    reset_button = 1'b1;
    #1;
    chk("rst_a_outputs", int'({ia.audio_addr, ia.tone_en, ia.busy, ia.active_id, ia.pending}), 0);
    chk("rst_b_outputs", int'({ib.audio_addr, ib.tone_en, ib.busy, ib.active_id, ib.pending}), 0);
    model_clear();
    repeat (2) @(posedge clk50mhz);
    #1 reset_button = 1'b0;
  endtask
  function automatic logic [3:0] rand_req();
    return $urandom_range(0, 29) == 0 ? 4'($urandom_range(1, 15)) : 4'b0;
  endfunction
  initial begin
    int n;
    ia.sfx_req = '0;
    ib.sfx_req = '0;
    model_clear();
    #1 rst_pulse();
    repeat (3) cyc(0, 0);
    // single request
    cyc(4'b0001, 0);
    chk("single_pending", int'(ia.pending), 4'b0001);
    cyc(0, 0);
    chk("single_tone_en", int'(ia.tone_en), 1);
    chk("single_active", int'(ia.active_id), 0);
    chk("single_cleared", int'(ia.pending), 0);
    n = 0;
    while (ia.tone_en && n < 1000) begin
      n++;
      if (ia.audio_addr != 0) chk("single_addr", int'(ia.audio_addr), 0);
      cyc(0, 0);
    end
    chk("single_length", n, 20);
    repeat (3) cyc(0, 0);
    // simultaneous requests
    cyc(4'b0110, 0);
    cyc(0, 0);
    chk("simul_first", int'(ia.active_id), 2);
    n = 0;
    while (ia.tone_en && ia.active_id == 2 && n < 1000) begin
      n++;
      if (ia.pending != 4'b0010) chk("simul_loser_pending", int'(ia.pending), 4'b0010);
      cyc(0, 0);
    end
    chk("simul_id2_length", n, 32);
    chk("simul_gap", int'(ia.tone_en), 0);
    cyc(0, 0);
    chk("simul_second", int'(ia.active_id), 1);
    n = 0;
    while (ia.tone_en && n < 1000) begin
      n++;
      cyc(0, 0);
    end
    chk("simul_id1_length", n, 12);
    repeat (3) cyc(0, 0);
    // preemption
    cyc(4'b0001, 0);
    repeat (10) cyc(0, 0);
    cyc(4'b1000, 0);
    cyc(0, 0);
    chk("preempt_active", int'(ia.active_id), 3);
    chk("preempt_addr", int'(ia.audio_addr), 0);
    n = 0;
    while (ia.tone_en && n < 2000) begin
      n++;
      if (ia.active_id != 3) chk("preempt_no_resume", int'(ia.active_id), 3);
      cyc(0, 0);
    end
    chk("preempt_length", n, 400);
    repeat (5) cyc(0, 0);
    chk("preempt_after_busy", int'(ia.busy), 0);
    chk("preempt_after_pending", int'(ia.pending), 0);
    // lower-priority wait
    cyc(4'b1000, 0);
    cyc(0, 0);
    repeat (5) cyc(0, 0);
    cyc(4'b0010, 0);
    n = 0;
    while (ia.tone_en && ia.active_id == 3 && n < 2000) begin
      n++;
      if (ia.pending != 4'b0010) chk("wait_pending", int'(ia.pending), 4'b0010);
      cyc(0, 0);
    end
    chk("wait_gap", int'(ia.tone_en), 0);
    cyc(0, 0);
    chk("wait_started", int'(ia.active_id), 1);
    // reset mid id3
    repeat (20) cyc(0, 0);
    cyc(4'b1000, 0);
    repeat (50) cyc(0, 0);
    rst_pulse();
    repeat (30) cyc(0, 0);
    chk("post_reset_busy", int'(ia.busy), 0);
    // address stepping on the long-tick instance, random traffic on the short one
    cyc(0, 4'b1000);
    cyc(rand_req(), 0);
    chk("step_start", int'(ib.active_id), 3);
    for (int t = 1; t <= 24738; t++) begin
      cyc(rand_req(), 0);
      if (t == 3985)  chk("step_g_before", int'(ib.audio_addr), 0);
      if (t == 3986)  chk("step_g_first", int'(ib.audio_addr), 1);
      if (t == 19999) chk("step_g_end", int'(ib.audio_addr), 5);
      if (t == 20000) chk("step_e_start", int'(ib.audio_addr), 5);
      if (t == 24737) chk("step_e_before", int'(ib.audio_addr), 5);
      if (t == 24738) chk("step_e_first", int'(ib.audio_addr), 6);
    end
    rst_pulse();
    repeat (5) cyc(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
